audio_pwm_player: RTL and testbench
===================================

// Module: audio_pwm_player
// PURPOSE
//  Consumes 16-bit audio words from the SPI audio receiver (its audio_out/data_ready pair).
//  Buffers them in a small FIFO, then plays one sample per sample-rate tick as a PWM waveform.
//  Drives an external RC low-pass filter / amplifier.
//  Decouples the bursty SPI arrival rate from the fixed playback rate; single clock domain (clock_max).
// PARAMETERS
//  FIFO_DEPTH   16   sample FIFO entries; power of 2, >=4
//  PREFILL      8    FIFO level required before playback starts; 1..FIFO_DEPTH
//  SAMPLE_DIV   521  clock_max cycles per sample tick (25 MHz / 48 kHz); >=2
//  PWM_BITS     8    PWM resolution; carrier period = 2**PWM_BITS clocks; 4..12
// PORTS
//  clock_max     in   1                 system clock, 25 MHz
//  reset         in   1                 asynchronous, active-high
//  sample_in     in   16                signed two's-complement sample (receiver audio_out)
//  sample_valid  in   1                 receiver data_ready; level or pulse
//  enable        in   1                 1 = play, 0 = stop reading FIFO
//  pwm_out       out  1                 registered PWM audio output
//  fifo_level    out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  playing       out  1                 1 while in PLAYING state
//  overflow      out  1                 sticky: write dropped because FIFO full
//  underrun      out  1                 sticky: tick found FIFO empty while PLAYING
// BEHAVIOUR
//  Reset (async):
//   - pwm_out=0, fifo_level=0, playing=0, overflow=0, underrun=0.
//   - FIFO pointers 0; tick and PWM counters 0; duty=2**(PWM_BITS-1); held sample=0.
//   - Reset mid-playback discards all FIFO contents.
//  Write:
//   - Exactly one write per rising edge of sample_valid (registered previous value); a held-high level never writes twice.
//   - Write is accepted when level<FIFO_DEPTH, or when a read happens in the same cycle.
//   - Otherwise the sample is dropped and overflow<=1.
//  Tick:
//   - Free-running counter 0..SAMPLE_DIV-1; tick asserts on the cycle count==SAMPLE_DIV-1, then wraps to 0.
//  FSM:
//   - IDLE: no reads; duty target = mid-scale 2**(PWM_BITS-1).
//     -> PLAYING when enable=1 and fifo_level>=PREFILL.
//   - PLAYING: on each tick, if FIFO is non-empty, pop one entry into the held sample.
//     If empty, keep the held sample and set underrun<=1.
//     -> IDLE when enable=0; FIFO is kept, not flushed.
//  Simultaneous read+write: level unchanged; both pointers advance (mod FIFO_DEPTH).
//  Flags: overflow and underrun clear only on reset or on a rising edge of enable.
//  Conversion:
//   - u = {~s[15], s[14:0]} (offset binary).
//   - duty_next = u[15 -: PWM_BITS].
//   - Examples: 0x7FFF -> all ones; 0x8000 -> 0; 0x0000 -> mid-scale.
//  PWM:
//   - Counter c runs 0..2**PWM_BITS-1 and wraps.
//   - duty register loads duty_next only when c wraps to 0 (glitch-free).
//   - pwm_out <= (c < duty). duty=0 gives constant 0; all-ones gives 1 for 2**PWM_BITS-1 of 2**PWM_BITS cycles.
//  Latency: popped sample reaches duty at the next PWM period boundary, i.e. <=2**PWM_BITS+1 clocks after the tick.
// CONFIGURATION
//  Macro AUDIO_ATTEN_EN:
//   - Defined: adds input port atten[3:0]. The held sample is arithmetically shifted right (>>>) by atten before conversion.
//     atten is sampled at the same point as duty_next.
//   - Not defined: no atten port; the sample is converted unchanged.
// TESTING
//  T1 reset: assert reset mid-run -> all outputs 0 at once; after release, IDLE, pwm_out high 128 of 256 clocks.
//  T2 playback: enable=1, write 8 samples 0x7FFF,0x8000,0x0000,... -> playing=1 within 1 clk of level=8.
//     Duty per tick: 255, then 0, then 128.
//  T3 overflow: enable=0, write 17 samples -> fifo_level=16, overflow=1, 17th sample never played.
//  T4 underrun: prefill 8, play past empty -> underrun=1 at 9th tick; duty holds the 8th sample; playing stays 1.
//  T5 level-held valid: sample_valid high 100 clocks -> fifo_level +1 only; write coincident with tick pop -> level unchanged.
//  T6 AUDIO_ATTEN_EN: sample 0x4000 with atten=2 -> treated as 0x1000; duty = 0x90.

Source files
------------

// File: rtl/audio_pwm_player_if.sv
// -----------------------------------------------------------------------------
// audio_pwm_player_if
//   Sample stream from the SPI audio receiver into the PWM player.
//   sample_in    : 16-bit signed two's-complement sample (receiver audio_out)
//   sample_valid : receiver data_ready; level or pulse, one write per rising edge
//   master : receiver side (drives the stream)
//   slave  : player side (consumes the stream)
// -----------------------------------------------------------------------------
interface audio_pwm_player_if;
  logic [15:0] sample_in;
  logic        sample_valid;

  modport master (
    output sample_in,
    output sample_valid
  );

  modport slave (
    input sample_in,
    input sample_valid
  );
endinterface

// File: rtl/audio_pwm_player.sv
// -----------------------------------------------------------------------------
// audio_pwm_player
//   Buffers 16-bit audio samples from the SPI receiver in a small FIFO and plays
//   one sample per sample-rate tick as a PWM waveform for an external RC
//   low-pass filter / amplifier. Single clock domain (clock_max).
//
// Parameters
//   FIFO_DEPTH  sample FIFO entries (power of 2, >=4)
//   PREFILL     FIFO level needed before playback starts (1..FIFO_DEPTH)
//   SAMPLE_DIV  clock_max cycles per sample tick (>=2)
//   PWM_BITS    PWM resolution; carrier period 2**PWM_BITS clocks (4..12)
//
// Ports
//   clock_max   in   system clock
//   reset       in   asynchronous, active-high
//   rx          in   sample stream (audio_pwm_player_if.slave)
//   enable      in   1 = play, 0 = stop reading the FIFO
//   atten       in   [3:0] arithmetic right shift of the held sample
//                    (only when AUDIO_ATTEN_EN is defined)
//   pwm_out     out  registered PWM audio output
//   fifo_level  out  current FIFO occupancy
//   playing     out  1 while in the PLAYING state
//   overflow    out  sticky: write dropped because the FIFO was full
//   underrun    out  sticky: tick found the FIFO empty while playing
//
// Configuration
//   AUDIO_ATTEN_EN  when defined, adds the atten port and attenuates the held
//                   sample before conversion; otherwise the sample is used as is.
// -----------------------------------------------------------------------------
module audio_pwm_player #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PREFILL    = 8,
  parameter int unsigned SAMPLE_DIV = 521,
  parameter int unsigned PWM_BITS   = 8
) (
  input  logic                        clock_max,
  input  logic                        reset,
  audio_pwm_player_if.slave           rx,
  input  logic                        enable,
`ifdef AUDIO_ATTEN_EN
  input  logic [3:0]                  atten,
`endif
  output logic                        pwm_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        playing,
  output logic                        overflow,
  output logic                        underrun
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(SAMPLE_DIV);

  localparam logic [AW:0]          DEPTH_L   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]          PREFILL_L = (AW+1)'(PREFILL);
  localparam logic [TW-1:0]        TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [PWM_BITS-1:0]  DUTY_MID  = PWM_BITS'(1) << (PWM_BITS - 1);

  typedef enum logic {
    IDLE,
    PLAYING
  } state_t;

  state_t state_q, state_d;

  logic                valid_q;
  logic                enable_q;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [15:0]         mem [FIFO_DEPTH];
  logic [TW-1:0]       tick_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_next;
  logic [15:0]         held_q;
  logic signed [15:0]  scaled;

  logic wr_req;
  logic wr_en;
  logic rd_en;
  logic enable_rise;

  // ---------------------------------------------------------------------------
  // Sample-rate tick
  // ---------------------------------------------------------------------------
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clock_max or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Write / read qualification
  // ---------------------------------------------------------------------------
  // Edge detect so a held-high data_ready never writes twice.
  assign wr_req      = rx.sample_valid && !valid_q;
  assign enable_rise = enable && !enable_q;
  assign rd_en       = (state_q == PLAYING) && enable && tick && (fifo_level != '0);
  // A same-cycle pop frees a slot, so a full FIFO can still accept.
  assign wr_en       = wr_req && ((fifo_level < DEPTH_L) || rd_en);

  always_ff @(posedge clock_max or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      valid_q  <= rx.sample_valid;
      enable_q <= enable;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_max) begin
    if (wr_en) begin
      mem[wr_ptr] <= rx.sample_in;
    end
  end

  always_ff @(posedge clock_max or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      held_q     <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
        held_q <= mem[rd_ptr];
      end
      unique case ({wr_en, rd_en})
        2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky status flags
  // ---------------------------------------------------------------------------
  // Clear on enable rising edge; a set event in the same cycle takes priority.
  always_ff @(posedge clock_max or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (enable_rise) begin
        overflow <= 1'b0;
        underrun <= 1'b0;
      end
      if (wr_req && !wr_en) begin
        overflow <= 1'b1;
      end
      if ((state_q == PLAYING) && enable && tick && (fifo_level == '0)) begin
        underrun <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Playback FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_max or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable && (fifo_level >= PREFILL_L)) begin
          state_d = PLAYING;
        end
      end
      PLAYING: begin
        if (!enable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign playing = (state_q == PLAYING);

  // ---------------------------------------------------------------------------
  // Sample -> duty conversion
  // ---------------------------------------------------------------------------
  always_comb begin
`ifdef AUDIO_ATTEN_EN
    scaled = $signed(held_q) >>> atten;
`else
    scaled = $signed(held_q);
`endif
    // Offset binary, then keep the top PWM_BITS bits.
    duty_next = PWM_BITS'({~scaled[15], scaled[14:0]} >> (16 - PWM_BITS));
    if (state_q == IDLE) begin
      duty_next = DUTY_MID;
    end
  end

  // ---------------------------------------------------------------------------
  // PWM carrier
  // ---------------------------------------------------------------------------
  // duty only changes as the counter wraps, so each carrier period is whole.
  always_ff @(posedge clock_max or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      duty_q  <= DUTY_MID;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      pwm_out <= (pwm_cnt < duty_q);
      if (pwm_cnt == '1) begin
        duty_q <= duty_next;
      end
    end
  end

endmodule

// File: tb/tb_audio_pwm_player.sv
// -----------------------------------------------------------------------------
// tb_audio_pwm_player
//   Directed bench for audio_pwm_player with a behavioural reference model
//   (sample queue, cycle-count arithmetic for tick and carrier) compared every
//   cycle, plus literal expectations on duty (high count per carrier period),
//   level and flags.
// -----------------------------------------------------------------------------
module tb_audio_pwm_player;

  localparam int SDIV   = 521;
  localparam int PERIOD = 256;
  localparam int DEPTH  = 16;
  localparam int PFILL  = 8;

  logic       clock_max = 1'b0;
  logic       reset     = 1'b0;
  logic       enable    = 1'b0;
  logic       pwm_out;
  logic [4:0] fifo_level;
  logic       playing;
  logic       overflow;
  logic       underrun;
`ifdef AUDIO_ATTEN_EN
  logic [3:0] atten = 4'd0;
`endif

  audio_pwm_player_if rx ();

  audio_pwm_player #(
    .FIFO_DEPTH (DEPTH),
    .PREFILL    (PFILL),
    .SAMPLE_DIV (SDIV),
    .PWM_BITS   (8)
  ) dut (
    .clock_max  (clock_max),
    .reset      (reset),
    .rx         (rx),
    .enable     (enable),
`ifdef AUDIO_ATTEN_EN
    .atten      (atten),
`endif
    .pwm_out    (pwm_out),
    .fifo_level (fifo_level),
    .playing    (playing),
    .overflow   (overflow),
    .underrun   (underrun)
  );

  always #5 clock_max = ~clock_max;

  int n_cmp = 0;
  int n_mis = 0;
  bit cmp_en = 1'b0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [15:0] m_q[$];
  int          m_cyc;
  int          m_duty;
  int          m_ptick = 0;
  int          m_size0;
  int          m_target;
  int          m_att;
  logic [15:0] m_held;
  bit          m_playing, m_ovf, m_unr, m_pwm, m_prev_valid, m_prev_en;
  bit          m_tick, m_rd, m_rise, m_acc;

  function automatic int duty_of(input logic [15:0] s, input int att);
    logic signed [15:0] sh;
    logic [15:0]        u;
    sh = $signed(s) >>> att;
    u  = sh + 16'h8000;
    return int'(u) / 256;
  endfunction

  initial begin
    forever begin
      @(posedge clock_max or posedge reset);
      if (reset) begin
        m_q.delete();
        m_cyc = 0; m_duty = 128; m_held = '0;
        m_playing = 0; m_ovf = 0; m_unr = 0; m_pwm = 0;
        m_prev_valid = 0; m_prev_en = 0;
      end else begin
`ifdef AUDIO_ATTEN_EN
        m_att = int'(atten);
`else
        m_att = 0;
`endif
        m_tick   = (m_cyc % SDIV) == SDIV - 1;
        m_size0  = m_q.size();
        m_target = m_playing ? duty_of(m_held, m_att) : 128;
        m_pwm    = (m_cyc % PERIOD) < m_duty;
        if ((m_cyc % PERIOD) == PERIOD - 1) m_duty = m_target;
        m_rd   = m_playing && enable && m_tick && (m_size0 > 0);
        m_rise = rx.sample_valid && !m_prev_valid;
        m_acc  = m_rise && ((m_size0 < DEPTH) || m_rd);
        if (enable && !m_prev_en) begin m_ovf = 0; m_unr = 0; end
        if (m_rise && !m_acc) m_ovf = 1;
        if (m_playing && enable && m_tick) begin
          m_ptick++;
          if (m_size0 == 0) m_unr = 1;
        end
        if (m_rd)  m_held = m_q.pop_front();
        if (m_acc) m_q.push_back(rx.sample_in);
        m_playing    = m_playing ? enable : (enable && (m_size0 >= PFILL));
        m_prev_valid = rx.sample_valid;
        m_prev_en    = enable;
        m_cyc++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model
  // ---------------------------------------------------------------------------
  logic [8:0] got_v, exp_v;
  initial begin
    forever begin
      @(negedge clock_max);
      if (cmp_en) begin
        got_v = {pwm_out, playing, overflow, underrun, fifo_level};
        exp_v = {m_pwm, m_playing, m_ovf, m_unr, 5'(m_q.size())};
        n_cmp++;
        if (got_v !== exp_v) begin
          n_mis++;
          $display("FAIL model_cycle t=%0t {pwm,play,ovf,unr,level}: got %b_%b_%b_%b_%0d expected %b_%b_%b_%b_%0d",
                   $time, got_v[8], got_v[7], got_v[6], got_v[5], got_v[4:0],
                   exp_v[8], exp_v[7], exp_v[6], exp_v[5], exp_v[4:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic write_sample(input logic [15:0] s);
    @(negedge clock_max);
    rx.sample_in    = s;
    rx.sample_valid = 1'b1;
    @(negedge clock_max);
    rx.sample_valid = 1'b0;
  endtask

  // Return on the negedge just after the model counts the target playing tick.
  task automatic wait_ptick(input int target);
    int budget;
    int n;
    budget = SDIV * (target - m_ptick + 1) + 16;
    n = 0;
    while (m_ptick < target && n < budget) begin
      @(negedge clock_max);
      n++;
    end
    if (m_ptick < target) check("ptick_timeout", m_ptick, target);
  endtask

  // Count pwm_out highs over the first full carrier period that begins after now.
  task automatic count_period(input string name, input int exp);
    int  highs;
    bit  found;
    highs = 0;
    found = 1'b0;
    for (int i = 0; i < PERIOD + 8 && !found; i++) begin
      @(negedge clock_max);
      if ((m_cyc % PERIOD) == 0) found = 1'b1;
    end
    if (!found) begin
      check({name, "_boundary_timeout"}, 0, 1);
    end else begin
      for (int i = 0; i < PERIOD; i++) begin
        @(negedge clock_max);
        highs += int'(pwm_out);
      end
      check(name, highs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  logic [15:0] t2_vec [8];
  int          base;
  int          n;

  initial begin
    t2_vec = '{16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF,
               16'h8000, 16'h0000, 16'h7FFF, 16'h4000};
    rx.sample_in    = '0;
    rx.sample_valid = 1'b0;

    #1 reset = 1'b1;
    #1 cmp_en = 1'b1;
    check("reset_pwm_out",    int'(pwm_out),    0);
    check("reset_fifo_level", int'(fifo_level), 0);
    check("reset_playing",    int'(playing),    0);
    check("reset_flags",      int'({overflow, underrun}), 0);
    #19 reset = 1'b0;

    // T1: idle carrier at mid-scale
    count_period("t1_idle_duty", 128);

    // T2: prefill then play
    @(negedge clock_max);
    enable = 1'b1;
    base = m_ptick;
    foreach (t2_vec[i]) write_sample(t2_vec[i]);
    check("t2_level_prefilled", int'(fifo_level), 8);
    @(negedge clock_max);
    check("t2_playing_after_prefill", int'(playing), 1);
    wait_ptick(base + 1);
    count_period("t2_duty_7fff", 255);
    wait_ptick(base + 2);
    count_period("t2_duty_8000", 0);
    wait_ptick(base + 3);
    count_period("t2_duty_0000", 128);

    // T4: drain and run past empty
    wait_ptick(base + 8);
    check("t4_no_underrun_at_8th", int'(underrun), 0);
    wait_ptick(base + 9);
    check("t4_underrun_at_9th", int'(underrun), 1);
    check("t4_still_playing",   int'(playing),  1);
    count_period("t4_holds_8th_sample", 192);

    // T5: held-high valid writes once; write coincident with a pop
    @(negedge clock_max);
    enable = 1'b0;
    repeat (3) @(negedge clock_max);
    check("t5_idle_after_disable", int'(playing), 0);
    rx.sample_in    = 16'h2000;
    rx.sample_valid = 1'b1;
    repeat (100) @(negedge clock_max);
    rx.sample_valid = 1'b0;
    @(negedge clock_max);
    check("t5_level_held_valid", int'(fifo_level), 1);
    for (int i = 0; i < 7; i++) write_sample(16'h0000);
    check("t5_level_refilled", int'(fifo_level), 8);
    enable = 1'b1;
    n = 0;
    while (!m_playing && n < 8) begin @(negedge clock_max); n++; end
    check("t5_replay_started", int'(playing), 1);
    check("t5_underrun_cleared", int'(underrun), 0);
    n = 0;
    while ((m_cyc % SDIV) != SDIV - 1 && n < SDIV + 4) begin @(negedge clock_max); n++; end
    rx.sample_in    = 16'h6000;
    rx.sample_valid = 1'b1;
    @(negedge clock_max);
    rx.sample_valid = 1'b0;
    check("t5_level_rw_same_cycle", int'(fifo_level), 8);

    // T1: asynchronous reset mid-playback
    repeat (5) @(negedge clock_max);
    #3 reset = 1'b1;
    enable = 1'b0;
    #1;
    check("t1_async_pwm_out",    int'(pwm_out),    0);
    check("t1_async_fifo_level", int'(fifo_level), 0);
    check("t1_async_playing",    int'(playing),    0);
    check("t1_async_flags",      int'({overflow, underrun}), 0);
    #12 reset = 1'b0;
    count_period("t1_post_reset_duty", 128);

    // T3: overflow; 17th sample dropped and never played
    for (int i = 0; i < 16; i++) write_sample(16'h8000);
    write_sample(16'h7FFF);
    @(negedge clock_max);
    check("t3_level_full", int'(fifo_level), 16);
    check("t3_overflow",   int'(overflow),   1);
    enable = 1'b1;
    base = m_ptick;
    repeat (2) @(negedge clock_max);
    check("t3_overflow_cleared", int'(overflow), 0);
    wait_ptick(base + 16);
    check("t3_no_underrun_at_16th", int'(underrun), 0);
    wait_ptick(base + 17);
    check("t3_underrun_at_17th", int'(underrun), 1);
    count_period("t3_17th_not_played", 0);

`ifdef AUDIO_ATTEN_EN
    // T6: attenuation by 2 of 0x4000 -> 0x1000 -> duty 0x90
    @(negedge clock_max);
    #3 reset = 1'b1;
    enable = 1'b0;
    #12 reset = 1'b0;
    atten  = 4'd2;
    enable = 1'b1;
    base = m_ptick;
    write_sample(16'h4000);
    for (int i = 0; i < 7; i++) write_sample(16'h0000);
    wait_ptick(base + 1);
    count_period("t6_atten_duty", 144);
`endif

    repeat (4) @(negedge clock_max);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_mis++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $fatal(1, "watchdog");
  end

endmodule
